dma_bus_controller: RTL and testbench

Owns the single memory port between the `cpu` core and external memory, and schedules a block-copy DMA engine onto it. A CPU write to a trigger address starts a copy of `LEN` bytes from page `{page, 8'h00}` to a fixed destination port (sprite-copy style). While the copy runs, the CPU is stalled via `cpu_rdy`. When idle, the block is a transparent pass-through from CPU bus to memory bus.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_bus_controller.sv | 117 +++++++++++
 tb/tb_dma_bus_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
//------------------------------------------------------------------------------
// dma_pkg : shared state encoding and default constants for the DMA bus controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] DMA_DEST_ADDR_DEF = 16'h2004;
    localparam int          DMA_LEN_DEF       = 256;

endpackage

`default_nettype wire

// File: rtl/dma_bus_controller.sv
//------------------------------------------------------------------------------
// dma_bus_controller : arbitrates the single memory port between the CPU and a
//                      page-to-port block-copy DMA engine that stalls the CPU.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dma_bus_controller
    import dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] DMA_DEST_ADDR = DMA_DEST_ADDR_DEF,
    parameter int          LEN           = DMA_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic        cpu_read_write,
    input  logic [7:0]  cpu_data_write,
    output logic [7:0]  cpu_data_read,
    output logic        cpu_rdy,
    output logic [15:0] mem_address,
    output logic        mem_read_write,
    output logic [7:0]  mem_data_write,
    input  logic [7:0]  mem_data_read,
    output logic        dma_busy
);

    localparam logic [7:0] IDX_LAST = 8'(LEN - 1);

    dma_state_e state;
    dma_state_e state_next;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_buf;
    logic       trigger;

    assign trigger = (cpu_address == DMA_REG_ADDR) && !cpu_read_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // idx stays 8 bits: LEN <= 256 means the source never carries into the page byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page     <= 8'h00;
            idx      <= 8'h00;
            data_buf <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        page <= cpu_data_write;
                        idx  <= 8'h00;
                    end
                end
                ST_READ: begin
                    data_buf <= mem_data_read;
                end
                ST_WRITE: begin
                    if (idx != IDX_LAST) begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        mem_address    = cpu_address;
        mem_read_write = cpu_read_write;
        mem_data_write = cpu_data_write;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                mem_address    = {page, 8'h00};
                mem_read_write = 1'b1;
                mem_data_write = data_buf;
                state_next     = ST_READ;
            end
            ST_READ: begin
                mem_address    = {page, idx};
                mem_read_write = 1'b1;
                mem_data_write = data_buf;
                state_next     = ST_WRITE;
            end
            ST_WRITE: begin
                mem_address    = DMA_DEST_ADDR;
                mem_read_write = 1'b0;
                mem_data_write = data_buf;
                state_next     = (idx == IDX_LAST) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status is decoded from the state register only
    assign cpu_rdy       = (state == ST_IDLE);
    assign dma_busy      = (state != ST_IDLE);
    assign cpu_data_read = mem_data_read;

endmodule

`default_nettype wire

// File: tb/tb_dma_bus_controller.sv
//------------------------------------------------------------------------------
// tb_dma_bus_controller : self-checking bench for dma_bus_controller (LEN=256 and LEN=4)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dma_bus_controller;

    localparam int L = 256;

    logic        clk;
    logic        rst;

    logic [15:0] a_addr, a_maddr;
    logic        a_rw, a_mrw, a_rdy, a_busy;
    logic [7:0]  a_wd, a_rd, a_mwd, a_mrd;

    logic [15:0] b_addr, b_maddr;
    logic        b_rw, b_mrw, b_rdy, b_busy;
    logic [7:0]  b_wd, b_rd, b_mwd, b_mrd;

    logic [7:0]  mem [0:65535];

    logic [15:0] a_rd_q[$];
    logic [23:0] a_wr_q[$];
    logic [15:0] b_rd_q[$];
    logic [23:0] b_wr_q[$];

    int checks   = 0;
    int failures = 0;

    assign a_mrd = mem[a_maddr];
    assign b_mrd = mem[b_maddr];

    dma_bus_controller u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .cpu_address    (a_addr),
        .cpu_read_write (a_rw),
        .cpu_data_write (a_wd),
        .cpu_data_read  (a_rd),
        .cpu_rdy        (a_rdy),
        .mem_address    (a_maddr),
        .mem_read_write (a_mrw),
        .mem_data_write (a_mwd),
        .mem_data_read  (a_mrd),
        .dma_busy       (a_busy)
    );

    dma_bus_controller #(.LEN(4)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .cpu_address    (b_addr),
        .cpu_read_write (b_rw),
        .cpu_data_write (b_wd),
        .cpu_data_read  (b_rd),
        .cpu_rdy        (b_rdy),
        .mem_address    (b_maddr),
        .mem_read_write (b_mrw),
        .mem_data_write (b_mwd),
        .mem_data_read  (b_mrd),
        .dma_busy       (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: records every access the DMA engine makes while busy
    always @(posedge clk) begin
        if (a_busy) begin
            if (a_mrw) a_rd_q.push_back(a_maddr);
            else       a_wr_q.push_back({a_maddr, a_mwd});
        end
        if (b_busy) begin
            if (b_mrw) b_rd_q.push_back(b_maddr);
            else       b_wr_q.push_back({b_maddr, b_mwd});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full LEN=256 copy on DUT A, checked against the reference: the block
    // mem[{page,k}] must appear at the destination in order, with a 1+2*L stall.
    task automatic run_xfer(input logic [7:0] page);
        int stall;
        a_rd_q.delete();
        a_wr_q.delete();
        a_addr = 16'h4014; a_rw = 1'b0; a_wd = page;
        #1;
        check("trig_fwd_addr", a_maddr, 16'h4014);
        check("trig_fwd_rw", a_mrw, 1'b0);
        check("trig_fwd_data", a_mwd, page);
        check("trig_rdy", a_rdy, 1'b1);
        next_cycle();
        a_addr = 16'($urandom); a_rw = 1'($urandom); a_wd = 8'($urandom);
        #1;
        check("start_rdy", a_rdy, 1'b0);
        check("start_busy", a_busy, 1'b1);
        check("start_addr", a_maddr, {page, 8'h00});
        check("start_rw", a_mrw, 1'b1);
        stall = 1;
        while (stall < 3000) begin
            next_cycle();
            if (a_rdy) break;
            stall++;
            a_addr = 16'($urandom); a_rw = 1'($urandom); a_wd = 8'($urandom);
        end
        a_addr = 16'h0123; a_rw = 1'b1; a_wd = 8'h00;
        #1;
        check("stall_cycles", stall, 1 + 2 * L);
        check("post_busy", a_busy, 1'b0);
        check("post_passthru", a_maddr, 16'h0123);
        check("wr_count", a_wr_q.size(), L);
        check("rd_count", a_rd_q.size(), L + 1);
        if (a_rd_q.size() == L + 1 && a_wr_q.size() == L) begin
            check("rd_start", a_rd_q[0], {page, 8'h00});
            for (int k = 0; k < L; k++) begin
                logic [15:0] src;
                src = {page, 8'h00} + 16'(k);
                check("rd_addr", a_rd_q[k + 1], src);
                check("wr_addr", a_wr_q[k][23:8], 16'h2004);
                check("wr_data", a_wr_q[k][7:0], mem[src]);
            end
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wd;
        logic [7:0]  memv;
        logic [15:0] exp_maddr;
        logic        exp_mrw;
        logic [7:0]  exp_mwd;
        logic [7:0]  exp_rd;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   stall_b;
        int   low_hits;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        b_addr = 16'h0000; b_rw = 1'b1; b_wd = 8'h00;

        // Reset: asynchronous, observed without a clock edge
        rst = 1'b0;
        a_addr = 16'hC0DE; a_rw = 1'b0; a_wd = 8'h5F;
        #3;
        check("rst_rdy", a_rdy, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_passthru", a_maddr, 16'hC0DE);
        next_cycle();
        next_cycle();
        check("rst_hold_rdy", a_rdy, 1'b1);
        rst = 1'b1;
        a_addr = 16'h0000; a_rw = 1'b1;
        next_cycle();

        // Pass-through vectors
        vecs[0] = '{16'h1234, 1'b1, 8'h00, 8'h77, 16'h1234, 1'b1, 8'h00, 8'h77};
        vecs[1] = '{16'h0300, 1'b0, 8'hA5, 8'h11, 16'h0300, 1'b0, 8'hA5, 8'h11};
        vecs[2] = '{16'h4014, 1'b1, 8'h99, 8'h42, 16'h4014, 1'b1, 8'h99, 8'h42};
        vecs[3] = '{16'h4015, 1'b0, 8'h05, 8'h00, 16'h4015, 1'b0, 8'h05, 8'h00};
        vecs[4] = '{16'h2004, 1'b0, 8'h3C, 8'hC3, 16'h2004, 1'b0, 8'h3C, 8'hC3};
        vecs[5] = '{16'hFFFF, 1'b1, 8'hE1, 8'h1E, 16'hFFFF, 1'b1, 8'hE1, 8'h1E};
        for (int i = 0; i < 6; i++) begin
            mem[vecs[i].addr] = vecs[i].memv;
            a_addr = vecs[i].addr; a_rw = vecs[i].rw; a_wd = vecs[i].wd;
            #1;
            check("vec_maddr", a_maddr, vecs[i].exp_maddr);
            check("vec_mrw", a_mrw, vecs[i].exp_mrw);
            check("vec_mwd", a_mwd, vecs[i].exp_mwd);
            check("vec_rd", a_rd, vecs[i].exp_rd);
            next_cycle();
            check("vec_no_stall", a_rdy, 1'b1);
        end

        // Random pass-through (trigger address excluded)
        for (int i = 0; i < 16; i++) begin
            a_addr = 16'($urandom); a_rw = 1'($urandom); a_wd = 8'($urandom);
            if (a_addr == 16'h4014) a_addr = 16'h4016;
            #1;
            check("rnd_maddr", a_maddr, a_addr);
            check("rnd_mrw", a_mrw, a_rw);
            check("rnd_mwd", a_mwd, a_wd);
            check("rnd_rd", a_rd, mem[a_addr]);
            next_cycle();
            check("rnd_no_stall", a_rdy, 1'b1);
        end

        // Full transfer with the documented pattern
        for (int k = 0; k < 256; k++) mem[16'h0200 + k] = 8'(k) ^ 8'h5A;
        run_xfer(8'h02);

        // Page 0xFF must stay in 0xFF00..0xFFFF
        for (int k = 0; k < 256; k++) mem[16'hFF00 + k] = 8'($urandom);
        run_xfer(8'hFF);
        low_hits = 0;
        foreach (a_rd_q[i]) if (a_rd_q[i][15:8] == 8'h00) low_hits++;
        check("page_ff_no_wrap", low_hits, 0);

        // Random pages and contents
        for (int r = 0; r < 2; r++) begin
            logic [7:0] pg;
            pg = 8'($urandom);
            for (int k = 0; k < 256; k++) mem[{pg, 8'h00} + 16'(k)] = 8'($urandom);
            run_xfer(pg);
        end

        // Reset mid-transfer while READ of idx 0x40 is on the bus
        a_addr = 16'h4014; a_rw = 1'b0; a_wd = 8'h07;
        next_cycle();
        a_addr = 16'h0000; a_rw = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (a_busy && a_mrw && a_maddr == 16'h0740) break;
            next_cycle();
        end
        check("mid_reached_idx40", a_maddr, 16'h0740);
        #2;
        rst = 1'b0;
        a_addr = 16'hBEEF; a_rw = 1'b0; a_wd = 8'h33;
        #1;
        check("mid_rst_rdy", a_rdy, 1'b1);
        check("mid_rst_busy", a_busy, 1'b0);
        check("mid_rst_maddr", a_maddr, 16'hBEEF);
        check("mid_rst_mrw", a_mrw, 1'b0);
        check("mid_rst_mwd", a_mwd, 8'h33);
        next_cycle();
        #4;
        rst = 1'b1;
        next_cycle();
        check("mid_post_rdy", a_rdy, 1'b1);
        for (int k = 0; k < 256; k++) mem[16'h0300 + k] = 8'($urandom);
        run_xfer(8'h03);

        // LEN = 4 instance
        for (int k = 0; k < 4; k++) mem[16'h1000 + k] = 8'($urandom);
        b_rd_q.delete();
        b_wr_q.delete();
        b_addr = 16'h4014; b_rw = 1'b0; b_wd = 8'h10;
        next_cycle();
        b_addr = 16'h0000; b_rw = 1'b1;
        stall_b = 0;
        while (stall_b < 100) begin
            if (b_rdy) break;
            stall_b++;
            next_cycle();
        end
        check("b_stall_cycles", stall_b, 9);
        check("b_wr_count", b_wr_q.size(), 4);
        check("b_rd_count", b_rd_q.size(), 5);
        if (b_wr_q.size() == 4 && b_rd_q.size() == 5) begin
            for (int k = 0; k < 4; k++) begin
                check("b_rd_addr", b_rd_q[k + 1], 16'h1000 + 16'(k));
                check("b_wr_addr", b_wr_q[k][23:8], 16'h2004);
                check("b_wr_data", b_wr_q[k][7:0], mem[16'h1000 + k]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
